// File: rtl/enc_event_fifo.sv
// rtl/enc_event_fifo.sv - encoder event detector feeding a show-ahead FIFO with overflow tracking
module enc_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DEDUP  = 1,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 enc_code,
    input  logic                       enc_valid,
    output logic [1:0]                 out_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          prev_valid;
    logic [1:0]    prev_code;

    logic evt;
    logic pop;
    logic push_ok;
    logic drop;
    logic dedup_off;

    // Event detection and handshake qualification; all terms come from registers or enc_* into state only
    always_comb begin
        dedup_off = (DEDUP == 0);
        evt       = enc_valid & (dedup_off | !prev_valid | (enc_code != prev_code));
        pop       = out_valid & out_ready;
        push_ok   = evt & (!full | pop);
        drop      = evt & full & !pop;
    end

    assign out_valid = (cnt != '0);
    assign full      = (cnt == FULL_LVL);
    assign level     = cnt;
    assign out_code  = mem[rd_ptr];

    // Previous-sample registers used for de-duplicating held encoder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_code  <= 2'b00;
        end else begin
            prev_valid <= enc_valid;
            prev_code  <= enc_code;
        end
    end

    // Storage array; cleared on reset so the head reads 0 until the first push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= enc_code;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a drop in the clearing cycle takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_enc_event_fifo.sv
// tb/tb_enc_event_fifo.sv - directed self-checking bench for enc_event_fifo
module tb_enc_event_fifo;

    logic       clk;
    logic       rst_n;
    logic [1:0] enc_code;
    logic       enc_valid;
    logic [1:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       full;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] drop_cnt;

    logic [1:0] e0_code;
    logic       e0_valid;
    logic [1:0] o0_code;
    logic       o0_valid;
    logic       r0_ready;
    logic [2:0] l0_level;
    logic       f0_full;
    logic       v0_ovf;
    logic [7:0] d0_cnt;

    int checks   = 0;
    int failures = 0;
    int pops;

    enc_event_fifo #(.DEPTH(4), .DEDUP(1), .DROP_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enc_code(enc_code), .enc_valid(enc_valid),
        .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    enc_event_fifo #(.DEPTH(4), .DEDUP(0), .DROP_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enc_code(e0_code), .enc_valid(e0_valid),
        .out_code(o0_code), .out_valid(o0_valid), .out_ready(r0_ready),
        .level(l0_level), .full(f0_full), .overflow(v0_ovf), .ovf_clr(1'b0),
        .drop_cnt(d0_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enc_code = 2'b00; enc_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        e0_code = 2'b00; e0_valid = 1'b0; r0_ready = 1'b0;
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // held code with dedup queues one event
        enc_valid = 1'b1; enc_code = 2'b01;
        tick();
        chk("t1_level_first", level, 1);
        chk("t1_valid_first", out_valid, 1);
        chk("t1_code_first", out_code, 2'b01);
        for (int i = 0; i < 4; i++) tick();
        chk("t1_level_held", level, 1);
        enc_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t1_drained", out_valid, 0);
        out_ready = 1'b0;

        // fill with four distinct codes, then a fifth event is dropped
        enc_valid = 1'b1;
        enc_code = 2'b00; tick();
        enc_code = 2'b01; tick();
        enc_code = 2'b10; tick();
        enc_code = 2'b11; tick();
        chk("t2_level_full", level, 4);
        chk("t2_full", full, 1);
        chk("t2_no_ovf_yet", overflow, 0);
        enc_code = 2'b10; tick();
        chk("t2_overflow", overflow, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_level_still", level, 4);
        tick();
        chk("t2_held_no_drop", drop_cnt, 1);
        chk("t2_head", out_code, 2'b00);

        // pop and push while full: accepted, no drop
        enc_valid = 1'b0; tick();
        enc_valid = 1'b1; enc_code = 2'b10; out_ready = 1'b1;
        tick();
        chk("t3_level", level, 4);
        chk("t3_drop_cnt", drop_cnt, 1);
        enc_valid = 1'b0;
        chk("t3_d1", out_code, 2'b01); tick();
        chk("t3_d2", out_code, 2'b10); tick();
        chk("t3_d3", out_code, 2'b11); tick();
        chk("t3_tail", out_code, 2'b10); tick();
        chk("t3_empty", out_valid, 0);
        chk("t3_level0", level, 0);
        tick();
        chk("t3_empty_ready", level, 0);
        out_ready = 1'b0;

        // saturation of the drop counter
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4_clr_ovf", overflow, 0);
        chk("t4_clr_cnt", drop_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            enc_valid = 1'b1; enc_code = 2'(i); tick();
            enc_valid = 1'b0; tick();
        end
        chk("t4_full", full, 1);
        for (int i = 0; i < 300; i++) begin
            enc_valid = 1'b1; tick();
            enc_valid = 1'b0; tick();
        end
        chk("t4_sat", drop_cnt, 8'hff);
        chk("t4_ovf", overflow, 1);
        chk("t4_level", level, 4);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4_clr2_ovf", overflow, 0);
        chk("t4_clr2_cnt", drop_cnt, 0);
        ovf_clr = 1'b1; enc_valid = 1'b1; tick();
        ovf_clr = 1'b0; enc_valid = 1'b0;
        chk("t4_dropwins_ovf", overflow, 1);
        chk("t4_dropwins_cnt", drop_cnt, 1);

        // asynchronous reset with three entries queued
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t6_level3", level, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_level", level, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_code", out_code, 0);
        chk("t6_full", full, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_cnt", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        enc_valid = 1'b1; enc_code = 2'b10; tick();
        enc_valid = 1'b0;
        chk("t6_new_level", level, 1);
        chk("t6_new_code", out_code, 2'b10);

        // DEDUP=0 instance: every valid cycle is an event
        pops = 0;
        e0_valid = 1'b1; e0_code = 2'b11; r0_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) e0_valid = 1'b0;
            if (o0_valid) begin
                pops++;
                chk("t5_pop_code", o0_code, 2'b11);
            end
            tick();
            if (i == 0) chk("t5_level_after1", l0_level, 1);
        end
        chk("t5_pops", pops, 3);
        chk("t5_level0", l0_level, 0);
        chk("t5_valid0", o0_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc_event_fifo.md
Name: enc_event_fifo

Overview:
Sits directly downstream of the 4-to-2 priority encoder and consumes its 2-bit code and valid flag. Turns the combinational encoder output into discrete, timestamp-free events and queues them in a small show-ahead FIFO. Events are drained by a consumer over a valid/ready handshake. Sticky overflow reporting and a saturating drop counter cover bursts the consumer cannot absorb.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
DEDUP, 1, 1 = push only on a new event (valid rising, or code change while valid); 0 = push every cycle valid is high.
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
enc_code  input  2  encoded index from the encoder (out).
enc_valid  input  1  encoder valid flag; enc_code is don't-care when 0.
out_code  output  2  head-of-FIFO code (show-ahead).
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head this cycle.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  level == DEPTH.
overflow  output  1  sticky; set when an event is dropped.
ovf_clr  input  1  synchronous clear of overflow and drop_cnt.
drop_cnt  output  DROP_W  number of dropped events, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): wr/rd pointers=0, level=0, out_valid=0, out_code=0, full=0, overflow=0, drop_cnt=0, prev_valid=0, prev_code=0.
- Every clock: prev_valid<=enc_valid, prev_code<=enc_code.
- Event detect (combinational): evt = enc_valid & (DEDUP==0 | !prev_valid | enc_code!=prev_code).
- pop = out_valid & out_ready. push_ok = evt & (!full | pop).
- push_ok: enc_code written at wr_ptr; wr_ptr increments with wrap at DEPTH.
- pop: rd_ptr increments with wrap. level += push_ok - pop.
- Latency: an event sampled at edge N appears on out_valid/out_code after edge N (visible in cycle N+1). out_code always shows mem[rd_ptr] and is 0-driven only by reset; contents are meaningless while out_valid=0.
- Full and pop in the same cycle: the push is accepted, level stays DEPTH, no drop.
- Full, evt, no pop: event dropped; overflow<=1; drop_cnt<=drop_cnt+1, saturating at all-ones.
- Empty and out_ready=1: no pop, no pointer change.
- Empty with push in the same cycle: no bypass; data is visible the next cycle.
- ovf_clr=1: overflow<=0, drop_cnt<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- DEDUP=1 with a held code: exactly one event is queued. Code change while valid stays high queues a new event. Valid low then high with the same code queues a new event.
- Reset mid-operation clears the queue immediately. Queued events are lost by design.
- Outputs are registered or derived only from registers (level, pointers). No combinational path from enc_* to out_*.

Test Plan:
1. Reset, DEDUP=1. Drive enc_valid=1, enc_code=2'b01 for 5 cycles, out_ready=0 -> level=1, out_code=01, out_valid=1 from the cycle after the first edge.
2. DEDUP=1, out_ready=0. Sequence codes 00,01,10,11 (each valid 1 cycle), then 10 held -> level=4, full=1. The 5th event is dropped: overflow=1, drop_cnt=1. Draining yields 00,01,10,11.
3. Full FIFO. Assert out_ready=1 and a new event (code 10) in the same cycle -> level stays 4, no drop. Tail after drain is 10.
4. Full FIFO, out_ready=0, 300 distinct events (toggle valid) -> drop_cnt=255, saturated. ovf_clr=1 -> overflow=0, drop_cnt=0 next cycle.
5. DEDUP=0, enc_valid=1, code 11 for 3 cycles with out_ready=1 -> three 11 pops, level returns to 0, out_valid=0 afterwards.
6. With level=3, pull rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock. After release, pointers restart at 0 and the first new event reads back correctly.
